// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Two-source round-robin arbiter. It drives the select of the downstream 2:1
// mux and owns the output register that captures the mux result.
//
// Optional build macro:
//   MUX_ARB_FIXED_PRIO_EN - when defined, in0 always wins contention and the
//                           idle select defaults to 0. The round-robin pointer
//                           is still updated but does not steer arbitration.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in0_valid/data/ready  source 0 handshake (ready = accepted this cycle)
//   in1_valid/data/ready  source 1 handshake
//   s                     combinational mux select for the current grant
//   out_valid/data/src    registered output word and its source index
//   out_ready             downstream consumes the word when out_valid is high
// -----------------------------------------------------------------------------
module mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             s,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } obuf_state_t;

    obuf_state_t      state_r;
    obuf_state_t      state_next_s;
    logic             last_r;
    logic [WIDTH-1:0] data_r;
    logic             src_r;

    logic             can_accept_s;
    logic             grant_valid_s;
    logic             grant_s;
    logic             accept_s;

    // 2:1 mux model of the downstream datapath: sel=0 picks a, sel=1 picks b.
    function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sel);
        logic [WIDTH-1:0] y;
        if (sel == 1'b1) begin
            y = b;
        end else begin
            y = a;
        end
        return y;
    endfunction

    // Grant selection; with no requester the select parks on the idle value.
    always_comb begin
        grant_valid_s = 1'b0;
`ifdef MUX_ARB_FIXED_PRIO_EN
        grant_s = 1'b0;
`else
        grant_s = last_r;
`endif
        if (in0_valid && in1_valid) begin
            grant_valid_s = 1'b1;
`ifdef MUX_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_r;
`endif
        end else if (in0_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
        end else if (in1_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // The register can take a word when empty or when it drains this cycle.
    // Readies are gated by rst_n so nothing is handshaken while in reset.
    always_comb begin
        can_accept_s = (state_r == EMPTY) || out_ready;
        accept_s     = rst_n && can_accept_s && grant_valid_s;
        in0_ready    = accept_s && (grant_s == 1'b0);
        in1_ready    = accept_s && (grant_s == 1'b1);
        s            = grant_s;
    end

    // Output buffer next state: accept refills, a lone drain empties.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_next_s = FULL;
                end else if (out_ready) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Output buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Captured word, its source and the round-robin pointer; last resets to 1
    // so in0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {WIDTH{1'b0}};
            src_r  <= 1'b0;
            last_r <= 1'b1;
        end else if (accept_s) begin
            data_r <= mux2(in0_data, in1_data, grant_s);
            src_r  <= grant_s;
            last_r <= grant_s;
        end
    end

    assign out_valid = (state_r == FULL);
    assign out_data  = data_r;
    assign out_src   = src_r;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

    localparam int WIDTH = 8;
`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             s;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    int n_vec = 0;
    int n_err = 0;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .s         (s),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = 8'hA5; in1_data = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        n_vec++; if (in0_ready !== 1'b0) begin n_err++; $display("FAIL rst_in0_ready got=%b exp=0", in0_ready); end
        n_vec++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL rst_in1_ready got=%b exp=0", in1_ready); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_vec++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_err++; $display("FAIL rst_first_grant got=%b%b exp=01", in1_ready, in0_ready); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL rst_first_s got=%b exp=0", s); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin
            n_err++; $display("FAIL rst_first_word got=%b/%h/%b exp=1/a5/0", out_valid, out_data, out_src); end
    endtask

    task automatic test_single_source();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in0_valid = 1'b0; in1_valid = 1'b1; in1_data = words[i]; #1;
            n_vec++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin n_err++; $display("FAIL single_ready[%0d] got=%b%b exp=10", i, in1_ready, in0_ready); end
            n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL single_s[%0d] got=%b exp=1", i, s); end
            @(posedge clk); #1;
            n_vec++; if (out_data !== words[i] || out_src !== 1'b1) begin
                n_err++; $display("FAIL single_word[%0d] got=%h/%b exp=%h/1", i, out_data, out_src, words[i]); end
        end
    endtask

    task automatic test_contention();
        logic exp_src;
        logic [7:0] exp_data;
        @(negedge clk);
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'hA5; in1_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            exp_src  = FIXED ? 1'b0 : ((i % 2) == 1);
            exp_data = exp_src ? 8'h3C : 8'hA5;
            #1;
            n_vec++; if (in0_ready !== !exp_src || in1_ready !== exp_src) begin
                n_err++; $display("FAIL cont_ready[%0d] got=%b%b exp_grant=%b", i, in1_ready, in0_ready, exp_src); end
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1 || out_data !== exp_data || out_src !== exp_src) begin
                n_err++; $display("FAIL cont_word[%0d] got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_src, exp_data, exp_src); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic exp_src;
        in0_data = 8'h5A; in1_data = 8'h3C; out_ready = 1'b1; #1;
        n_vec++; if (in0_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept got=%b exp=1", in0_ready); end
        @(posedge clk); #1;
        n_vec++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL bp_word got=%h exp=5a", out_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            n_vec++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, in1_ready, in0_ready); end
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/5a/0", i, out_valid, out_data, out_src); end
        end
        exp_src = FIXED ? 1'b0 : 1'b1;
        @(negedge clk); out_ready = 1'b1; #1;
        n_vec++; if (in0_ready !== !exp_src || in1_ready !== exp_src) begin
            n_err++; $display("FAIL bp_release_ready got=%b%b exp_grant=%b", in1_ready, in0_ready, exp_src); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== (exp_src ? 8'h3C : 8'h5A)) begin
            n_err++; $display("FAIL bp_release_word got=%b/%h/%b exp_src=%b", out_valid, out_data, out_src, exp_src); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in0_valid = 1'b1; in1_valid = 1'b0; in0_data = 8'h77;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin n_err++; $display("FAIL mr_load got=%b/%h exp=1/77", out_valid, out_data); end
        @(negedge clk); in0_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; in1_data = 8'h99; #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_async_clear got=%b exp=0", out_valid); end
        n_vec++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_err++; $display("FAIL mr_ready_in_reset got=%b%b exp=00", in1_ready, in0_ready); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL mr_no_accept got=%b/%h exp=0/00", out_valid, out_data); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
        n_vec++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_err++; $display("FAIL mr_first_grant got=%b%b exp=01", in1_ready, in0_ready); end
        @(posedge clk); #1;
        n_vec++; if (out_src !== 1'b0 || out_data !== 8'h77) begin n_err++; $display("FAIL mr_first_word got=%h/%b exp=77/0", out_data, out_src); end
    endtask

`ifdef MUX_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        @(negedge clk);
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'hC3; in1_data = 8'h18;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL fp_in1_ready[%0d] got=%b exp=0", i, in1_ready); end
            @(posedge clk); #1;
            n_vec++; if (out_src !== 1'b0 || out_data !== 8'hC3) begin n_err++; $display("FAIL fp_word[%0d] got=%h/%b exp=c3/0", i, out_data, out_src); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_mid_reset();
`ifdef MUX_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-source round-robin arbiter that drives the select of the team's 2:1 mux and registers the selected word for the next stage. Each source presents a WIDTH-bit word under a valid/ready handshake. The block picks one source per cycle and forwards its data through the mux path into a single output register. It sits directly upstream of the mux and also owns the register that consumes the mux output.

## Interface
- WIDTH, 8, data width of each source and of the output word.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  source 0 has a word.
- in0_data  input  WIDTH  source 0 word.
- in0_ready  output  1  source 0 word accepted this cycle.
- in1_valid  input  1  source 1 has a word.
- in1_data  input  WIDTH  source 1 word.
- in1_ready  output  1  source 1 word accepted this cycle.
- s  output  1  combinational mux select for the current grant (0 selects in0, 1 selects in1).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  1  index of the source that produced out_data.
- out_ready  input  1  downstream consumes the word when out_valid is high.

## Operation
- State is held in three places:
  - Output register: states EMPTY (out_valid=0) and FULL (out_valid=1).
  - Round-robin pointer `last`: index of the most recent grant.
  - Data and source registers.
- can_accept = !out_valid || out_ready.
- Grant rules:
  - Only in0_valid high: grant 0.
  - Only in1_valid high: grant 1.
  - Both high: grant the source that is not `last`.
  - Neither high: no grant.
- s equals the grant index when a grant exists; otherwise s equals `last`.
- inK_ready = can_accept && grant==K. At most one ready is high per cycle. A ready never asserts for a source whose valid is low.
- On accept:
  - out_data <= mux(in0_data, in1_data, s).
  - out_src <= s.
  - out_valid <= 1.
  - last <= s.
- If out_ready is high while FULL and nothing is accepted, the register goes to EMPTY (out_valid <= 0).
- While FULL and out_ready is low, out_data, out_src and out_valid hold stable, and both readies stay low.
- Sources may drop valid without a handshake. The arbiter does not lock a grant across cycles.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, last=1, so in0 wins the first contention. in0_ready=0 and in1_ready=0 whenever both valids are low.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N.
- Throughput: 1 word per cycle when out_ready is held high. A simultaneous drain and accept in the same cycle is allowed.
- Continuous contention alternates grants 0,1,0,1,… with no bubbles.
- Reset asserted mid-transfer:
  - out_valid clears immediately, asynchronously, and any held word is discarded.
  - `last` returns to 1.
  - Readies are low while rst_n is low.
- Reset deassertion takes effect at the first rising clk edge after rst_n goes high. No accept occurs in the cycle in which rst_n is low.

## Configuration
- MUX_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. in0 always wins when both sources are valid. `last` is still updated but is ignored for arbitration, and s defaults to 0 when idle.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset check:
  - Stimulus: hold rst_n=0 with in0_valid=in1_valid=1.
  - Required: out_valid=0, out_data=0, in0_ready=in1_ready=0.
  - Stimulus: release rst_n.
  - Required: first grant goes to in0, and out_data equals in0_data one cycle later.
- Contention alternation:
  - Stimulus: in0_data=0xA5, in1_data=0x3C, both valid for 4 cycles, out_ready=1.
  - Required: out_data sequence 0xA5, 0x3C, 0xA5, 0x3C; out_src sequence 0, 1, 0, 1.
- Single source:
  - Stimulus: in1_valid=1 only for 3 cycles, in1_data=0x11, 0x22, 0x33.
  - Required: each word forwarded with out_src=1, in0_ready stays 0, and the next contention grants in0.
- Backpressure:
  - Stimulus: word 0x5A accepted, then out_ready=0 for 3 cycles with both valids high.
  - Required: out_data holds 0x5A, readies stay 0. When out_ready rises, the drain and the next accept happen in the same cycle.
- Mid-operation reset:
  - Stimulus: assert rst_n low while out_valid=1 (out_data=0x77).
  - Required: out_valid drops without waiting for clk. After release, the first contention grants in0.
- Fixed priority (build with MUX_ARB_FIXED_PRIO_EN):
  - Stimulus: both valid for 4 cycles.
  - Required: out_src is 0 every cycle and in1_ready is never asserted.
